// File: rtl/hidden_layer_mac.sv
// Hidden DNN layer: four neurons, one input index per cycle,
// bias + ReLU + shift + saturate to 0..15.
module hidden_layer_mac #(
    parameter logic [79:0] W     = {16{5'b00001}},
    parameter logic [31:0] B     = 32'd0,
    parameter int unsigned SHIFT = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       input_ready,
    input  logic [4:0] in0,
    input  logic [4:0] in1,
    input  logic [4:0] in2,
    input  logic [4:0] in3,
    output logic [4:0] out0,
    output logic [4:0] out1,
    output logic [4:0] out2,
    output logic [4:0] out3,
    output logic       output_ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        ACT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic               rdy_q, rdy_d;
    logic signed [11:0] acc_q [4];
    logic signed [11:0] acc_d [4];
    logic [4:0]         in_q  [4];
    logic [4:0]         in_d  [4];
    logic [4:0]         out_q [4];
    logic [4:0]         out_d [4];
    logic [4:0]         w_sel [4];
    logic signed [9:0]  prod  [4];
    logic [4:0]         in_sel;

    function automatic logic [4:0] activate(input logic signed [11:0] a);
        logic signed [11:0] r;
        logic signed [11:0] s;
        r = a[11] ? 12'sd0 : a;
        s = r >>> SHIFT;
        return (s > 12'sd15) ? 5'd15 : s[4:0];
    endfunction

    assign in_sel = in_q[idx_q];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rdy_d   = 1'b0;
        for (int n = 0; n < 4; n++) begin
            acc_d[n] = acc_q[n];
            in_d[n]  = in_q[n];
            out_d[n] = out_q[n];
            w_sel[n] = W[(n * 4 + int'(idx_q)) * 5 +: 5];
            prod[n]  = $signed({{5{in_sel[4]}}, in_sel})
                     * $signed({{5{w_sel[n][4]}}, w_sel[n]});
        end
        unique case (state_q)
            IDLE: begin
                if (input_ready) begin
                    in_d[0] = in0;
                    in_d[1] = in1;
                    in_d[2] = in2;
                    in_d[3] = in3;
                    for (int n = 0; n < 4; n++) begin
                        acc_d[n] = {{4{B[n * 8 + 7]}}, B[n * 8 +: 8]};
                    end
                    idx_d   = 2'd0;
                    state_d = MAC;
                end
            end
            MAC: begin
                for (int n = 0; n < 4; n++) begin
                    acc_d[n] = acc_q[n] + {{2{prod[n][9]}}, prod[n]};
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) state_d = ACT;
            end
            ACT: begin
                for (int n = 0; n < 4; n++) begin
                    out_d[n] = activate(acc_q[n]);
                end
                rdy_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            rdy_q   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                acc_q[n] <= 12'sd0;
                in_q[n]  <= 5'd0;
                out_q[n] <= 5'd0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdy_q   <= rdy_d;
            for (int n = 0; n < 4; n++) begin
                acc_q[n] <= acc_d[n];
                in_q[n]  <= in_d[n];
                out_q[n] <= out_d[n];
            end
        end
    end

    assign out0         = out_q[0];
    assign out1         = out_q[1];
    assign out2         = out_q[2];
    assign out3         = out_q[3];
    assign output_ready = rdy_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_hidden_layer_mac.sv
// Directed bench for hidden_layer_mac: default, SHIFT=2 and
// custom-weight instances share one input stream.
module tb_hidden_layer_mac;

    localparam logic [79:0] W_CUST =
        {60'd0, 5'b00000, 5'b00010, 5'b11111, 5'b00001};
    localparam logic [31:0] B_CUST = {24'd0, 8'hFD};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       input_ready = 1'b0;
    logic [4:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;

    logic [4:0] d_o [4];
    logic [4:0] s_o [4];
    logic [4:0] w_o [4];
    logic       d_rdy, s_rdy, w_rdy;
    logic       d_busy, s_busy, w_busy;

    int n_chk  = 0;
    int n_fail = 0;
    int d_pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (d_rdy) d_pulses++;

    hidden_layer_mac u_def (
        .clk(clk), .rst_n(rst_n), .input_ready(input_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out0(d_o[0]), .out1(d_o[1]), .out2(d_o[2]), .out3(d_o[3]),
        .output_ready(d_rdy), .busy(d_busy)
    );

    hidden_layer_mac #(.SHIFT(2)) u_sh (
        .clk(clk), .rst_n(rst_n), .input_ready(input_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out0(s_o[0]), .out1(s_o[1]), .out2(s_o[2]), .out3(s_o[3]),
        .output_ready(s_rdy), .busy(s_busy)
    );

    hidden_layer_mac #(.W(W_CUST), .B(B_CUST)) u_w (
        .clk(clk), .rst_n(rst_n), .input_ready(input_ready),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .out0(w_o[0]), .out1(w_o[1]), .out2(w_o[2]), .out3(w_o[3]),
        .output_ready(w_rdy), .busy(w_busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int which,
                            input int e0, input int e1,
                            input int e2, input int e3);
        int e [4];
        e = '{e0, e1, e2, e3};
        for (int n = 0; n < 4; n++) begin
            int v;
            v = (which == 0) ? int'(d_o[n]) :
                (which == 1) ? int'(s_o[n]) : int'(w_o[n]);
            chk($sformatf("%s_out%0d", tag, n), v, e[n]);
        end
    endtask

    task automatic set_in(input int a, input int b,
                          input int c, input int d);
        in0 = 5'(a);
        in1 = 5'(b);
        in2 = 5'(c);
        in3 = 5'(d);
    endtask

    // Returns one cycle after the capture edge E0.
    task automatic send(input int a, input int b,
                        input int c, input int d);
        set_in(a, b, c, d);
        input_ready = 1'b1;
        tick();
        input_ready = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        rst_n = 1'b0;
        input_ready = 1'b1;
        set_in(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
               int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
        ticks(2);
        chk_outs("rst_def", 0, 0, 0, 0, 0);
        chk("rst_busy", int'(d_busy), 0);
        chk("rst_rdy", int'(d_rdy), 0);
        input_ready = 1'b0;
        rst_n = 1'b1;
        tick();

        // Basic frame and latency
        send(3, 4, 5, 2);
        chk("f1_busy", int'(d_busy), 1);
        ticks(4);
        chk("f1_rdy_early", int'(d_rdy), 0);
        tick();
        chk("f1_rdy", int'(d_rdy), 1);
        chk("f1_busy_low", int'(d_busy), 0);
        chk_outs("f1_def", 0, 14, 14, 14, 14);
        chk_outs("f1_sh", 1, 3, 3, 3, 3);
        chk_outs("f1_w", 2, 6, 0, 0, 0);
        tick();
        chk("f1_rdy_drop", int'(d_rdy), 0);
        chk_outs("f1_hold", 0, 14, 14, 14, 14);

        // Saturation high
        send(15, 15, 15, 15);
        ticks(5);
        chk("sat_rdy", int'(d_rdy), 1);
        chk_outs("sat_def", 0, 15, 15, 15, 15);
        chk_outs("sat_sh", 1, 15, 15, 15, 15);
        chk_outs("sat_w", 2, 15, 0, 0, 0);
        tick();

        // ReLU on negative sums
        send(-16, -16, -16, -16);
        ticks(5);
        chk_outs("relu_def", 0, 0, 0, 0, 0);
        chk_outs("relu_sh", 1, 0, 0, 0, 0);
        chk_outs("relu_w", 2, 0, 0, 0, 0);
        tick();

        // Per-neuron weights and bias
        send(5, 2, 3, 7);
        ticks(5);
        chk_outs("pw_w", 2, 6, 0, 0, 0);
        chk_outs("pw_def", 0, 15, 15, 15, 15);
        chk_outs("pw_sh", 1, 4, 4, 4, 4);
        tick();

        // Shift
        send(7, 7, 7, 7);
        ticks(5);
        chk_outs("sh7_sh", 1, 7, 7, 7, 7);
        chk_outs("sh7_w", 2, 11, 0, 0, 0);
        tick();

        // Pulse while busy is dropped
        d_pulses = 0;
        send(1, 1, 1, 1);
        tick();
        set_in(9, 9, 9, 9);
        input_ready = 1'b1;
        tick();
        input_ready = 1'b0;
        ticks(3);
        chk("bd_rdy", int'(d_rdy), 1);
        chk_outs("bd_def", 0, 4, 4, 4, 4);
        chk_outs("bd_sh", 1, 1, 1, 1, 1);
        ticks(6);
        chk("bd_pulses", d_pulses, 1);
        chk_outs("bd_hold", 0, 4, 4, 4, 4);

        // Back-to-back frames with input_ready held high
        d_pulses = 0;
        set_in(2, 2, 2, 2);
        input_ready = 1'b1;
        tick();
        ticks(5);
        chk("bb1_rdy", int'(d_rdy), 1);
        chk_outs("bb1_def", 0, 8, 8, 8, 8);
        chk_outs("bb1_w", 2, 1, 0, 0, 0);
        set_in(3, 3, 3, 3);
        tick();
        input_ready = 1'b0;
        chk("bb2_busy", int'(d_busy), 1);
        ticks(5);
        chk("bb2_rdy", int'(d_rdy), 1);
        chk_outs("bb2_def", 0, 12, 12, 12, 12);
        chk_outs("bb2_sh", 1, 3, 3, 3, 3);
        chk_outs("bb2_w", 2, 3, 0, 0, 0);
        tick();
        chk("bb_pulses", d_pulses, 2);

        // Reset mid-frame after MAC idx=1
        d_pulses = 0;
        send(4, 4, 4, 4);
        ticks(2);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_busy", int'(d_busy), 0);
        ticks(6);
        chk("mr_pulses", d_pulses, 0);
        chk_outs("mr_def", 0, 0, 0, 0, 0);
        send(3, 4, 5, 2);
        ticks(5);
        chk("mr_rdy", int'(d_rdy), 1);
        chk_outs("mr_next", 0, 14, 14, 14, 14);
        chk_outs("mr_next_w", 2, 6, 0, 0, 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hidden_layer_mac.md
# hidden_layer_mac

Fully-connected hidden layer of the DNN. It sits directly downstream of the input layer and consumes that stage's four registered signed 5-bit activations plus its `output_ready` pulse. It computes four neurons with a time-multiplexed MAC: one input index per cycle, all four neurons in parallel. Each neuron adds a bias, applies ReLU, shifts and saturates, then emits four signed 5-bit activations with a one-cycle `output_ready` pulse for the next layer.

## Interface
Parameters:
- `W`, default all 16 fields = 5'sd1, packed 80-bit signed weights; the weight for neuron n and input i is `W[(n*4+i)*5 +: 5]`.
- `B`, default all 4 fields = 8'sd0, packed 32-bit signed biases; the bias for neuron n is `B[n*8 +: 8]`.
- `SHIFT`, default 0, arithmetic right shift (0..7) applied after ReLU.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `input_ready`  in  1  upstream valid pulse; in0..in3 are valid in the same cycle.
- `in0`..`in3`  in  5 each  signed activations from the input layer.
- `out0`..`out3`  out  5 each  signed neuron outputs, range 0..15.
- `output_ready`  out  1  one-cycle pulse; out0..out3 are valid in that cycle.
- `busy`  out  1  high while a computation is in flight.

## Operation
- The FSM has three states: IDLE, MAC and ACT.
- IDLE:
  - If `input_ready`=1, latch in0..in3 into an input register.
  - Load acc[n] <= sign-extended B[n] for each neuron n.
  - Set idx <= 0 and go to MAC.
  - Otherwise stay in IDLE.
- MAC:
  - Each cycle, acc[n] <= acc[n] + in_reg[idx]*W[n][idx] for all four neurons, using a 5x5 signed product of 10 bits.
  - idx counts 0..3. After idx=3 accumulates, go to ACT.
- ACT:
  - For each neuron, compute r = (acc < 0) ? 0 : acc; then s = r >>> SHIFT; then out = (s > 15) ? 15 : s.
  - Register out0..out3, pulse `output_ready`, and return to IDLE.
- Width rules:
  - acc is 12-bit signed. The worst case |4*256 + 128| = 1152 cannot overflow.
  - The multiply and add are fully signed. Saturation caps the output at +15, so the output sign bit is always 0.
- `input_ready` is ignored while `busy`=1. Inputs are not queued, the internal register does not change, and nothing is flagged. Upstream must space frames at least 6 cycles apart.
- out0..out3 hold their last ACT value until the next ACT; they are not zeroed between frames.
- `busy` = (state != IDLE), driven from registered state.

## Timing
- Reset, sampled on a `clk` edge with `rst_n`=0:
  - state returns to IDLE and idx=0.
  - acc, the input register, out0..out3, `output_ready` and `busy` all go to 0.
- Reset asserted mid-frame aborts the frame. No `output_ready` is produced for it.
- Edge E0 samples `input_ready`=1 in IDLE. Edges E1..E4 perform the MACs for idx 0..3. Edge E5 (ACT) registers the outputs.
- `output_ready` is high for exactly the one cycle following E5. Latency from the capture edge to outputs-valid is 5 clocks.
- `busy` is high in the cycles following E0 through E4 and low again after E5.
- At E5 the state returns to IDLE, so a new `input_ready` can be captured at E6. Minimum frame spacing is 6 cycles.
- If `input_ready`=1 during ACT (the cycle before E5), it is ignored.
- If `input_ready` is held high continuously, a frame is captured every 6 cycles, at E0, E6, E12, and so on.

## Test plan
- Reset: hold `rst_n`=0 for 2 clocks with random inputs. Required: all outputs 0 and `busy`=0. Then one frame in=(3,4,5,2) with default parameters gives out0..3=14, and `output_ready` high exactly 5 clocks after the capture edge.
- Saturation and ReLU with default parameters: in=(15,15,15,15) gives every output 15 (sum 60). In=(-16,-16,-16,-16) gives every output 0 (sum -64).
- Per-neuron weights and bias: set W[0][i]=(1,-1,2,0), B[0]=-3, and all other weights 0, then in=(5,2,3,7). Required: out0=relu(5-2+6-3)=6 and out1..3=0.
- Shift with SHIFT=2: in=(7,7,7,7) gives 7 (28>>2). In=(15,15,15,15) gives 15 (60>>2).
- Busy drop: send in=(1,1,1,1), then pulse `input_ready` with in=(9,9,9,9) 2 cycles later. Required: only one `output_ready`, with outputs 4, and back-to-back frames 6 cycles apart both complete correctly.
- Reset mid-frame: assert `rst_n`=0 at the edge after MAC idx=1. Required: no `output_ready`, outputs 0, and the next frame computes correctly.
